// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : FSM/owner encodings and counter sizing for mem_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STROBE = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // A zero timeout still needs a 1-bit counter to keep the RTL legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : fetch port, load/store port and memory bus of the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ack;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wmask;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ack;

  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rstrb;
  logic                  mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rbusy;
  logic                  mem_wbusy;

  logic                  bus_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_rbusy, mem_wbusy,
    output i_rdata, i_ack, d_rdata, d_ack,
           mem_addr, mem_wdata, mem_wmask, mem_rstrb, mem_wstrb, bus_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_rbusy, mem_wbusy,
    input  i_rdata, i_ack, d_rdata, d_ack,
           mem_addr, mem_wdata, mem_wmask, mem_rstrb, mem_wstrb, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick : combinational winner select between fetch and load/store.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention, else d wins.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_t rr_last,
`endif
  output owner_t grant
);

  always_comb begin
    grant = OWN_NONE;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = (rr_last == OWN_D) ? OWN_I : OWN_D;
`else
      grant = OWN_D;
`endif
    end else if (d_req) begin
      grant = OWN_D;
    end else if (i_req) begin
      grant = OWN_I;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory bus between fetch and load/store ports,
// one transaction at a time, with busy timeout. Macro: MEM_ARB_ROUND_ROBIN_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W     = cnt_width(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUSY_TIMEOUT);
  localparam logic             TO_EN     = (BUSY_TIMEOUT != 0);

  arb_state_t          state;
  owner_t              owner;
  owner_t              grant;
  logic                is_write;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                rstrb_q;
  logic                wstrb_q;
  logic                busy;
  logic                timeout_hit;
  logic                done;
  logic                ack_ok;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t              rr_last;
`endif

  mem_arb_pick u_pick (
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .rr_last (rr_last),
`endif
    .grant   (grant)
  );

  assign busy        = is_write ? bus.mem_wbusy : bus.mem_rbusy;
  assign timeout_hit = TO_EN && busy && (cnt == CNT_LIMIT);
  assign done        = (state == ARB_WAIT) && (!busy || timeout_hit);
  // A reset landing on the completing cycle abandons the transaction silently.
  assign ack_ok      = done && !rst;

  assign bus.i_ack   = ack_ok && (owner == OWN_I);
  assign bus.d_ack   = ack_ok && (owner == OWN_D);
  assign bus.bus_err = ack_ok && timeout_hit;
  assign bus.i_rdata = (bus.i_ack && !timeout_hit) ? bus.mem_rdata : '0;
  assign bus.d_rdata = (bus.d_ack && !timeout_hit) ? bus.mem_rdata : '0;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.mem_rstrb = rstrb_q;
  assign bus.mem_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      owner    <= OWN_NONE;
      is_write <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rstrb_q  <= 1'b0;
      wstrb_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last  <= OWN_I;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant != OWN_NONE) begin
            state <= ARB_STROBE;
            owner <= grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last <= grant;
`endif
            if (grant == OWN_D) begin
              addr_q   <= bus.d_addr;
              is_write <= bus.d_we;
              wstrb_q  <= bus.d_we;
              rstrb_q  <= !bus.d_we;
              wdata_q  <= bus.d_we ? bus.d_wdata : '0;
              wmask_q  <= bus.d_we ? bus.d_wmask : '0;
            end else begin
              addr_q   <= bus.i_addr;
              is_write <= 1'b0;
              rstrb_q  <= 1'b1;
            end
          end
        end
        ARB_STROBE: begin
          rstrb_q <= 1'b0;
          wstrb_q <= 1'b0;
          wmask_q <= '0;
          cnt     <= '0;
          state   <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (done) begin
            state    <= ARB_IDLE;
            owner    <= OWN_NONE;
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : randomized bench with a transaction-timeline reference model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requester state (held until the model says the ack happened)
  logic        i_pend = 1'b0, d_pend = 1'b0;
  logic [31:0] i_a = '0, d_a = '0, d_wd = '0;
  logic        d_w = 1'b0;
  logic [3:0]  d_m = '0;

  // current transaction as a timeline: strobe cycle, ack cycle, busy length
  int          next_free = 1;
  int          strobe_c  = -10;
  int          ack_c     = -10;
  int          bl        = 0;
  logic        t_d = 1'b0, t_we = 1'b0, t_err = 1'b0;
  logic [31:0] t_a = '0, t_wd = '0;
  logic [3:0]  t_m = '0;
  logic        rr_i_last = 1'b1;

  // phase knobs
  int p_i = 0, p_d = 0, l_fix = 0, l_max = 0, rst_pct = 0, dir = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] rd;
    logic        rst_now, grant_d, ack_now, act;
    @(posedge clk);
    #1;
    cyc++;
    if (!i_pend && ($urandom_range(99) < p_i)) begin
      i_pend = 1'b1;
      i_a    = (dir == 1) ? 32'h10 : $urandom;
    end
    if (!d_pend && ($urandom_range(99) < p_d)) begin
      d_pend = 1'b1;
      if (dir == 2) begin
        d_a = 32'h20; d_w = 1'b1; d_wd = 32'h1234_5678; d_m = 4'b0011;
      end else begin
        d_a = $urandom; d_w = 1'($urandom_range(1)); d_wd = $urandom; d_m = 4'($urandom);
      end
    end
    rst_now = (cyc > strobe_c) && (cyc <= ack_c) && ($urandom_range(99) < rst_pct);
    rd      = (dir == 1) ? 32'hDEAD_BEEF : $urandom;

    if (rst_now) begin
      ack_c     = cyc;
      next_free = cyc + 1;
      rr_i_last = 1'b1;
    end else if (cyc >= next_free) begin
      if (i_pend || d_pend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_d = d_pend && (!i_pend || rr_i_last);
`else
        grant_d = d_pend;
`endif
        rr_i_last = !grant_d;
        bl        = (l_fix >= 0) ? l_fix : int'($urandom_range(l_max));
        strobe_c  = cyc + 1;
        ack_c     = cyc + 2 + ((bl < TO) ? bl : TO);
        t_err     = (bl > TO);
        next_free = ack_c + 1;
        t_d       = grant_d;
        t_we      = grant_d && d_w;
        t_a       = grant_d ? d_a : i_a;
        t_wd      = d_wd;
        t_m       = d_m;
      end else begin
        next_free = cyc + 1;
      end
    end

    rst           = rst_now;
    bus.i_req     = i_pend;
    bus.i_addr    = i_a;
    bus.d_req     = d_pend;
    bus.d_we      = d_w;
    bus.d_addr    = d_a;
    bus.d_wdata   = d_wd;
    bus.d_wmask   = d_m;
    bus.mem_rdata = rd;
    bus.mem_rbusy = 1'($urandom_range(1));
    bus.mem_wbusy = 1'($urandom_range(1));
    if (cyc > strobe_c && cyc <= ack_c) begin
      if (t_we) bus.mem_wbusy = (cyc <= strobe_c + bl);
      else      bus.mem_rbusy = (cyc <= strobe_c + bl);
    end

    @(negedge clk);
    ack_now = (cyc == ack_c) && !rst_now;
    act     = (cyc >= strobe_c) && (cyc <= ack_c);
    check("rstrb",   64'(bus.mem_rstrb), 64'(cyc == strobe_c && !t_we));
    check("wstrb",   64'(bus.mem_wstrb), 64'(cyc == strobe_c && t_we));
    check("addr",    64'(bus.mem_addr),  64'(act ? t_a : 32'h0));
    check("wmask",   64'(bus.mem_wmask), 64'((cyc == strobe_c && t_we) ? t_m : 4'h0));
    if (cyc == strobe_c && t_we) check("wdata", 64'(bus.mem_wdata), 64'(t_wd));
    check("i_ack",   64'(bus.i_ack),     64'(ack_now && !t_d));
    check("d_ack",   64'(bus.d_ack),     64'(ack_now && t_d));
    check("bus_err", 64'(bus.bus_err),   64'(ack_now && t_err));
    check("i_rdata", 64'(bus.i_rdata),   64'((ack_now && !t_d && !t_err) ? rd : 32'h0));
    check("d_rdata", 64'(bus.d_rdata),   64'((ack_now && t_d && !t_err) ? rd : 32'h0));
    if (ack_now) begin
      if (t_d) d_pend = 1'b0;
      else     i_pend = 1'b0;
    end
  endtask

  task automatic phase(input int pi, input int pd, input int lf, input int lm,
                       input int rp, input int dr, input int n);
    p_i = pi; p_d = pd; l_fix = lf; l_max = lm; rst_pct = rp; dir = dr;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h55;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h66;
    bus.d_wdata   = 32'hFFFF_FFFF;
    bus.d_wmask   = 4'hF;
    bus.mem_rdata = 32'hA5A5_A5A5;
    bus.mem_rbusy = 1'b0;
    bus.mem_wbusy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_rstrb", 64'(bus.mem_rstrb), 64'h0);
      check("rst_wstrb", 64'(bus.mem_wstrb), 64'h0);
      check("rst_addr",  64'(bus.mem_addr),  64'h0);
      check("rst_wdata", 64'(bus.mem_wdata), 64'h0);
      check("rst_wmask", 64'(bus.mem_wmask), 64'h0);
      check("rst_acks",  64'({bus.i_ack, bus.d_ack, bus.bus_err}), 64'h0);
      check("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'h0);
    end

    phase(100,   0,  0, 0,  0, 1,   12);  // fetch only, 0x10 / DEADBEEF
    phase(  0, 100,  3, 0,  0, 2,   16);  // store 0x20, wbusy for 3 cycles
    phase(100, 100,  0, 0,  0, 0,   40);  // both continuously, no busy
    phase(100,   0,  9, 0,  0, 0,   24);  // rbusy stuck: timeouts
    phase(100,   0,  0, 0,  0, 0,   12);  // service resumes
    phase( 60,  60,  5, 0, 40, 0,   60);  // frequent reset in WAIT
    phase( 40,  50, -1, TO + 3, 5, 0, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
